// File: rtl/rbm_sample_accumulator.sv
// Iteration controller and saturating vote accumulator for the RBM inference chain.
// Define EARLY_STOP_EN to end a run once the leading class is ahead by early_margin.
module rbm_sample_accumulator #(
  parameter int                   bitlength      = 12,
  parameter int                   output_dim     = 2,
  parameter logic [bitlength-1:0] Inf            = 12'b0111_1111_1111,
  parameter int                   iter_width     = 16,
  parameter int                   early_margin   = 64,
  parameter int                   early_min_iter = 8
) (
  input  logic                                                 clock,
  input  logic                                                 reset,
  input  logic                                                 start,
  input  logic [iter_width-1:0]                                iter_num,
  output logic                                                 engine_reset,
  input  logic                                                 engine_finish,
  input  logic [output_dim*bitlength-1:0]                      engine_data,
  output logic [output_dim*bitlength-1:0]                      acc_data,
  output logic [iter_width-1:0]                                iter_count,
  output logic [((output_dim > 1) ? $clog2(output_dim) : 1)-1:0] argmax,
  output logic                                                 busy,
  output logic                                                 finish,
  output logic                                                 early_stop
);

  localparam int                          arg_w      = (output_dim > 1) ? $clog2(output_dim) : 1;
  localparam logic signed [bitlength:0]   margin_c   = (bitlength + 1)'(early_margin);
  localparam logic [iter_width-1:0]       min_iter_c = iter_width'(early_min_iter);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    WAIT  = 3'd2,
    ACCUM = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                          state_r;
  logic [iter_width-1:0]           target_r;
  logic [output_dim*bitlength-1:0] acc_r;
  logic [iter_width-1:0]           iter_count_r;
  logic [arg_w-1:0]                argmax_r;
  logic                            busy_r;
  logic                            finish_r;
  logic                            early_r;
  logic                            eng_rst_r;

  logic [output_dim*bitlength-1:0] sum_acc_s;
  logic [iter_width-1:0]           count_inc_s;
  logic                            last_iter_s;
  logic                            early_hit_s;
  logic [arg_w-1:0]                best_idx_s;
  logic [bitlength-1:0]            best_val_s;

  // Sum is formed one bit wider so that overflow can be seen and clamped to +/-Inf.
  function automatic logic [bitlength-1:0] sat_add(input logic [bitlength-1:0] a,
                                                   input logic [bitlength-1:0] b);
    logic signed [bitlength:0] sum_v;
    logic signed [bitlength:0] pos_v;
    logic signed [bitlength:0] neg_v;
    logic [bitlength-1:0]      res_v;
    sum_v = $signed({a[bitlength-1], a}) + $signed({b[bitlength-1], b});
    pos_v = $signed({1'b0, Inf});
    neg_v = -pos_v;
    if (sum_v > pos_v) begin
      res_v = Inf;
    end else if (sum_v < neg_v) begin
      res_v = neg_v[bitlength-1:0];
    end else begin
      res_v = sum_v[bitlength-1:0];
    end
    return res_v;
  endfunction

  // Per-channel saturating sum of the running vote and the current engine vector.
  always_comb begin
    sum_acc_s = '0;
    for (int g = 0; g < output_dim; g++) begin
      sum_acc_s[g*bitlength +: bitlength] = sat_add(acc_r[g*bitlength +: bitlength],
                                                    engine_data[g*bitlength +: bitlength]);
    end
  end

  assign count_inc_s = iter_count_r + {{(iter_width-1){1'b0}}, 1'b1};
  assign last_iter_s = (count_inc_s == target_r);

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx_s = '0;
    best_val_s = acc_r[bitlength-1:0];
    for (int g = 1; g < output_dim; g++) begin
      if ($signed(acc_r[g*bitlength +: bitlength]) > $signed(best_val_s)) begin
        best_val_s = acc_r[g*bitlength +: bitlength];
        best_idx_s = arg_w'(g);
      end else begin
        best_val_s = best_val_s;
      end
    end
  end

`ifdef EARLY_STOP_EN
  logic signed [bitlength-1:0] top_s;
  logic signed [bitlength-1:0] second_s;
  logic signed [bitlength-1:0] cand_s;
  logic signed [bitlength:0]   lead_s;

  // Lead of the best over the runner-up in the vector about to be stored.
  always_comb begin
    cand_s = '0;
    if ($signed(sum_acc_s[2*bitlength-1:bitlength]) > $signed(sum_acc_s[bitlength-1:0])) begin
      top_s    = $signed(sum_acc_s[2*bitlength-1:bitlength]);
      second_s = $signed(sum_acc_s[bitlength-1:0]);
    end else begin
      top_s    = $signed(sum_acc_s[bitlength-1:0]);
      second_s = $signed(sum_acc_s[2*bitlength-1:bitlength]);
    end
    for (int g = 2; g < output_dim; g++) begin
      cand_s = $signed(sum_acc_s[g*bitlength +: bitlength]);
      if (cand_s > top_s) begin
        second_s = top_s;
        top_s    = cand_s;
      end else if (cand_s > second_s) begin
        second_s = cand_s;
      end else begin
        second_s = second_s;
      end
    end
    lead_s      = {top_s[bitlength-1], top_s} - {second_s[bitlength-1], second_s};
    early_hit_s = (count_inc_s >= min_iter_c) && (lead_s >= margin_c);
  end
`else
  logic unused_cfg_s;
  assign early_hit_s  = 1'b0;
  assign unused_cfg_s = ^{margin_c, min_iter_c};
`endif

  // Run sequencing: pipeline restart pulse, accumulation, iteration count and status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      target_r     <= '0;
      acc_r        <= '0;
      iter_count_r <= '0;
      busy_r       <= 1'b0;
      finish_r     <= 1'b0;
      early_r      <= 1'b0;
      eng_rst_r    <= 1'b1;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          eng_rst_r <= 1'b0;
          if (start) begin
            target_r     <= iter_num;
            acc_r        <= '0;
            iter_count_r <= '0;
            early_r      <= 1'b0;
            if (iter_num == '0) begin
              state_r  <= DONE;
              busy_r   <= 1'b0;
              finish_r <= 1'b1;
            end else begin
              state_r   <= CLEAR;
              busy_r    <= 1'b1;
              finish_r  <= 1'b0;
              eng_rst_r <= 1'b1;
            end
          end
        end
        CLEAR: begin
          eng_rst_r <= 1'b0;
          state_r   <= WAIT;
        end
        WAIT: begin
          eng_rst_r <= 1'b0;
          if (engine_finish) begin
            state_r <= ACCUM;
          end
        end
        ACCUM: begin
          acc_r        <= sum_acc_s;
          iter_count_r <= count_inc_s;
          if (last_iter_s) begin
            state_r   <= DONE;
            busy_r    <= 1'b0;
            finish_r  <= 1'b1;
            eng_rst_r <= 1'b0;
          end else if (early_hit_s) begin
            state_r   <= DONE;
            busy_r    <= 1'b0;
            finish_r  <= 1'b1;
            early_r   <= 1'b1;
            eng_rst_r <= 1'b0;
          end else begin
            state_r   <= CLEAR;
            eng_rst_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          eng_rst_r <= 1'b0;
        end
      endcase
    end
  end

  // Winning-class register, one cycle behind the accumulator.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      argmax_r <= '0;
    end else begin
      argmax_r <= best_idx_s;
    end
  end

  assign engine_reset = eng_rst_r;
  assign acc_data     = acc_r;
  assign iter_count   = iter_count_r;
  assign argmax       = argmax_r;
  assign busy         = busy_r;
  assign finish       = finish_r;
  assign early_stop   = early_r;

endmodule

// File: tb/tb_rbm_sample_accumulator.sv
// Bench for rbm_sample_accumulator: vector table plus hand sequences, results checked
// through an expected-result queue. Define EARLY_STOP_EN here too when the DUT has it.
module tb_rbm_sample_accumulator;
  localparam int BW = 12;
  localparam int OD = 2;
  localparam int IW = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [IW-1:0]     iter_num = '0;
  logic              engine_reset;
  logic              engine_finish;
  logic [OD*BW-1:0]  engine_data = '0;
  logic [OD*BW-1:0]  acc_data;
  logic [IW-1:0]     iter_count;
  logic [0:0]        argmax;
  logic              busy;
  logic              finish;
  logic              early_stop;

  rbm_sample_accumulator dut (
    .clock(clock), .reset(reset), .start(start), .iter_num(iter_num),
    .engine_reset(engine_reset), .engine_finish(engine_finish), .engine_data(engine_data),
    .acc_data(acc_data), .iter_count(iter_count), .argmax(argmax),
    .busy(busy), .finish(finish), .early_stop(early_stop)
  );

  always #5 clock = ~clock;

  typedef struct {
    string name; int n; int d0; int d1; int dly;
    int e0; int e1; int ecnt; int eam; int eearly; int epul;
  } vec_t;

  typedef struct {
    string name; int acc0; int acc1; int cnt; int am; int early; int pul;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[5];
  int   errors = 0;
  int   checks = 0;
  int   p0 = 0;

  // Layer-pipeline model: counts restart pulses, raises engine_finish eng_dly cycles later.
  int eng_dly = 4;
  int pulses = 0;
  int cd = 0;
  bit spur_req = 1'b0;
  bit spur_done = 1'b0;
  initial begin
    engine_finish = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        cd = 0;
        engine_finish = 1'b0;
      end else if (engine_reset) begin
        pulses++;
        cd = eng_dly;
        if (spur_req && !spur_done) begin
          engine_finish = 1'b1;
          spur_done = 1'b1;
        end else begin
          engine_finish = 1'b0;
        end
      end else if (cd > 0) begin
        cd--;
        engine_finish = (cd == 0);
      end else begin
        engine_finish = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic start_run(input logic [IW-1:0] n);
    @(negedge clock);
    iter_num = n;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_finish(input string name, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (finish) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: finish not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic check_result();
    exp_t e;
    e = sb_q.pop_front();
    chk({e.name, "_acc0"}, $signed(acc_data[BW-1:0]), e.acc0);
    chk({e.name, "_acc1"}, $signed(acc_data[2*BW-1:BW]), e.acc1);
    chk({e.name, "_iter_count"}, iter_count, e.cnt);
    chk({e.name, "_busy_done"}, busy, 0);
    chk({e.name, "_early_stop"}, early_stop, e.early);
    chk({e.name, "_engine_resets"}, pulses - p0, e.pul);
    @(negedge clock);
    chk({e.name, "_argmax"}, argmax, e.am);
    chk({e.name, "_finish_hold"}, finish, 1);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    engine_data = {BW'(v.d1), BW'(v.d0)};
    eng_dly = v.dly;
    sb_q.push_back('{v.name, v.e0, v.e1, v.ecnt, v.eam, v.eearly, v.epul});
    p0 = pulses;
    start_run(IW'(v.n));
    chk({v.name, "_engine_reset_lat"}, engine_reset, 1);
    chk({v.name, "_busy"}, busy, 1);
    chk({v.name, "_finish_clr"}, finish, 0);
    wait_finish(v.name, 3000, ok);
    if (ok) check_result();
    else void'(sb_q.pop_front());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit hit;
    tbl[0] = '{"basic",    3,    -5,    10, 4,   -15,    30,   3, 1, 0,   3};
    tbl[1] = '{"sat",      4,  1500, -1500, 2,  2047, -2047,   4, 0, 0,   4};
    tbl[2] = '{"tie",      2,     7,     7, 1,    14,    14,   2, 0, 0,   2};
    tbl[3] = '{"neg_rail", 1, -2048,    -1, 3, -2047,    -1,   1, 1, 0,   1};
`ifdef EARLY_STOP_EN
    tbl[4] = '{"margin", 100,   10,     0, 1,    80,     0,   8, 0, 1,   8};
`else
    tbl[4] = '{"margin", 100,   10,     0, 1,  1000,     0, 100, 0, 0, 100};
`endif

    // asynchronous reset values
    #1 reset = 1'b1;
    #1;
    chk("rst_acc", acc_data, 0);
    chk("rst_iter_count", iter_count, 0);
    chk("rst_argmax", argmax, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    chk("rst_early", early_stop, 0);
    chk("rst_engine_reset", engine_reset, 1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);

    // zero-iteration run
    p0 = pulses;
    start_run(IW'(0));
    chk("zero_finish", finish, 1);
    chk("zero_engine_reset", engine_reset, 0);
    chk("zero_acc", acc_data, 0);
    chk("zero_iter_count", iter_count, 0);
    repeat (3) @(negedge clock);
    chk("zero_engine_resets", pulses - p0, 0);
    chk("zero_finish_hold", finish, 1);

    // start while busy and a stray engine_finish in CLEAR are both ignored
    engine_data = {BW'(2), BW'(1)};
    eng_dly = 4;
    spur_req = 1'b1;
    sb_q.push_back('{"busy_start", 3, 6, 3, 1, 0, 3});
    p0 = pulses;
    start_run(IW'(3));
    repeat (4) @(negedge clock);
    chk("busy_mid", busy, 1);
    chk("stray_finish_count", iter_count, 0);
    iter_num = IW'(9);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_finish("busy_start", 3000, ok);
    if (ok) check_result();
    else void'(sb_q.pop_front());

    // table vectors; the first one restarts from DONE
    for (int i = 0; i < 5; i++) begin
      run_vec(tbl[i]);
    end

    // reset during WAIT of iteration 2 of 5, then a full rerun
    engine_data = {BW'(-2), BW'(3)};
    eng_dly = 4;
    p0 = pulses;
    start_run(IW'(5));
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      #1;
      if (pulses - p0 >= 2) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL midrst_timeout: second engine_reset not seen");
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_acc", acc_data, 0);
    chk("midrst_iter_count", iter_count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_finish", finish, 0);
    chk("midrst_early", early_stop, 0);
    chk("midrst_argmax", argmax, 0);
    chk("midrst_engine_reset", engine_reset, 1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    run_vec('{"rst_rerun", 5, 3, -2, 4, 15, -10, 5, 0, 0, 5});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rbm_sample_accumulator.md
Name: rbm_sample_accumulator

Overview:
- Iteration controller and saturating accumulator for the RBM inference chain (hidden layer into classify layer).
- Restarts an external layer pipeline once per sample iteration, sums each per-iteration output vector with per-channel saturation, and reports the accumulated vote, the winning class and completion.
- Generalises the fixed-count top level:
  - run-time iteration count with start/busy handshake;
  - restart without global reset;
  - saturation at both rails;
  - argmax output;
  - optional early stop.

Parameters:
- bitlength, 12: width of each signed channel (two's complement).
- output_dim, 2: number of output channels/classes (>=2).
- Inf, 12'b0111_1111_1111: positive saturation value; negative rail is -Inf.
- iter_width, 16: width of iteration count/counter.
- early_margin, 64: lead of best over second-best channel that triggers early stop (EARLY_STOP_EN only).
- early_min_iter, 8: minimum completed iterations before early stop may fire (EARLY_STOP_EN only).

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  one-cycle request to begin a run; sampled only in IDLE or DONE.
- iter_num  input  iter_width  iterations to run; latched on accepted start.
- engine_reset  output  1  one-cycle pulse restarting the layer pipeline.
- engine_finish  input  1  layer pipeline has valid engine_data this cycle.
- engine_data  input  output_dim*bitlength  per-iteration output vector, channel g at bits [g*bitlength +: bitlength].
- acc_data  output  output_dim*bitlength  accumulated vector, same packing.
- iter_count  output  iter_width  completed iterations in current run.
- argmax  output  max(1,$clog2(output_dim))  index of largest acc_data channel.
- busy  output  1  high from accepted start until DONE.
- finish  output  1  high in DONE, held until next accepted start or reset.
- early_stop  output  1  high in DONE if run ended by margin rule.

Behaviour:
- Reset values: acc_data=0, iter_count=0, argmax=0, busy=0, finish=0, early_stop=0, engine_reset=1 while reset is asserted, FSM=IDLE.
- FSM states: IDLE, CLEAR, WAIT, ACCUM, DONE.
- IDLE/DONE + start:
  - latch iter_num; clear acc_data, iter_count, finish, early_stop;
  - busy=1 next cycle;
  - go to CLEAR, or to DONE if iter_num==0 (finish next cycle, acc_data=0).
- CLEAR: engine_reset=1 for exactly this cycle, then WAIT.
- WAIT: hold until engine_finish=1, then ACCUM. engine_finish outside WAIT is ignored.
- ACCUM (1 cycle):
  - for each g: acc[g] = sat(acc[g] + engine_data[g]); sum computed at bitlength+1 bits, clamped to [-Inf, Inf];
  - iter_count += 1;
  - if new iter_count == latched count -> DONE, else CLEAR.
- engine_data is captured in the ACCUM cycle. The pipeline must hold it stable from its engine_finish until engine_reset.
- Latency: start at cycle 0 -> engine_reset at cycle 1. Each iteration costs 3 cycles plus engine time. finish rises the cycle after the final ACCUM.
- DONE: busy=0, finish=1, acc_data frozen.
- argmax: registered, updated one cycle after acc_data changes. Ties resolve to the lowest index.
- start while busy is ignored. iter_num changes while busy have no effect.
- Reset mid-run: immediate abort to reset values. No engine_reset pulse beyond the reset assertion itself.
- Counter never wraps: terminal compare stops at the latched count, including the maximum 2^iter_width-1.

Optional Feature:
- Macro EARLY_STOP_EN.
- Defined: after each ACCUM with iter_count >= early_min_iter, compute best and second-best acc channels (bitlength+1-bit difference). If best - second >= early_margin, go to DONE with early_stop=1 even if iterations remain.
- Not defined: margin logic absent, early_stop tied 0, run always completes iter_num iterations.

Test Plan:
- iter_num=3, engine_data={ch1=10, ch0=-5} each iteration, engine_finish 4 cycles after each engine_reset -> exactly 3 engine_reset pulses; finish with acc={30,-15}; iter_count=3; argmax=1; busy low in DONE.
- Saturation, iter_num=4, ch0=+1500 and ch1=-1500 each iteration -> acc ch0=2047, ch1=-2047 with no wrap.
- iter_num=0 start -> finish one cycle later, acc=0, no engine_reset pulse.
- Second start mid-run, plus engine_finish pulse during CLEAR -> both ignored; run ends after the original count; second start after DONE clears acc and reruns.
- Reset asserted during WAIT of iteration 2 of 5 -> all outputs return to reset values asynchronously; a new start then runs 5 full iterations.
- EARLY_STOP_EN, margin 64, min_iter 8, iter_num=100, ch0=+10 and ch1=0 each iteration -> DONE after iteration 8 (lead 80), early_stop=1, iter_count=8. Without the macro the same stimulus runs 100 iterations, early_stop=0.
